// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage -> MEM/WB bundle. Defining MEM_ERRCNT_EN adds the ou_errcnt
// misaligned-access counter.
interface mem_stage_if;
    logic        in_valid;
    logic [31:0] in_add;
    logic        in_flag;
    logic [31:0] in_res;
    logic [31:0] in_dat2;
    logic [4:0]  in_mux;
    logic        in_memread;
    logic        in_memwrite;
    logic        in_branch;
    logic        in_memtoreg;
    logic        in_regwrite;
    logic        ou_pcsrc;
    logic [31:0] ou_brtarget;
    logic        ou_stall;
    logic        ou_valid;
    logic [31:0] ou_rdata;
    logic [31:0] ou_res;
    logic [4:0]  ou_mux;
    logic        ou_memtoreg;
    logic        ou_regwrite;
    logic        ou_misalign;
`ifdef MEM_ERRCNT_EN
    logic [15:0] ou_errcnt;
`endif

    modport master (
        output in_valid, in_add, in_flag, in_res, in_dat2, in_mux,
               in_memread, in_memwrite, in_branch, in_memtoreg, in_regwrite,
        input  ou_pcsrc, ou_brtarget, ou_stall, ou_valid, ou_rdata, ou_res,
               ou_mux, ou_memtoreg, ou_regwrite, ou_misalign
`ifdef MEM_ERRCNT_EN
        , input ou_errcnt
`endif
    );

    modport slave (
        input  in_valid, in_add, in_flag, in_res, in_dat2, in_mux,
               in_memread, in_memwrite, in_branch, in_memtoreg, in_regwrite,
        output ou_pcsrc, ou_brtarget, ou_stall, ou_valid, ou_rdata, ou_res,
               ou_mux, ou_memtoreg, ou_regwrite, ou_misalign
`ifdef MEM_ERRCNT_EN
        , output ou_errcnt
`endif
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, multi-cycle load/store on an internal word RAM.
// Optional MEM_ERRCNT_EN build adds a saturating misaligned-access counter.
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [0:0]  state_reg;
    logic [3:0]  cnt_reg;

    // Operands captured at accept; upstream holds EX/MEM while we stall anyway.
    logic [31:0] res_reg;
    logic [31:0] dat2_reg;
    logic [4:0]  mux_reg;
    logic        memtoreg_reg;
    logic        regwrite_reg;
    logic        store_reg;

    logic        valid_out_reg;
    logic [31:0] res_out_reg;
    logic [4:0]  mux_out_reg;
    logic        memtoreg_out_reg;
    logic        regwrite_out_reg;
    logic        misalign_out_reg;
    logic        rdata_sel_reg;

    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] ram_q;

    logic              is_mem;
    logic              misal;
    logic              done;
    logic [ADDR_W-1:0] idx;

    assign is_mem = bus.in_memread | bus.in_memwrite;
    assign misal  = is_mem & (bus.in_res[1:0] != 2'b00);
    assign done   = (state_reg == BUSY) && (cnt_reg == 4'd0);
    assign idx    = res_reg[ADDR_W+1:2];

    assign bus.ou_pcsrc    = bus.in_valid & bus.in_branch & bus.in_flag;
    assign bus.ou_brtarget = bus.in_add;
    assign bus.ou_stall    = (state_reg == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            res_reg          <= 32'd0;
            dat2_reg         <= 32'd0;
            mux_reg          <= 5'd0;
            memtoreg_reg     <= 1'b0;
            regwrite_reg     <= 1'b0;
            store_reg        <= 1'b0;
            valid_out_reg    <= 1'b0;
            res_out_reg      <= 32'd0;
            mux_out_reg      <= 5'd0;
            memtoreg_out_reg <= 1'b0;
            regwrite_out_reg <= 1'b0;
            misalign_out_reg <= 1'b0;
            rdata_sel_reg    <= 1'b0;
        end else begin
            valid_out_reg    <= 1'b0;
            misalign_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_mem && !misal) begin
                            res_reg      <= bus.in_res;
                            dat2_reg     <= bus.in_dat2;
                            mux_reg      <= bus.in_mux;
                            memtoreg_reg <= bus.in_memtoreg;
                            regwrite_reg <= bus.in_regwrite;
                            store_reg    <= bus.in_memwrite;
                            cnt_reg      <= 4'(MEM_LAT);
                            state_reg    <= BUSY;
                        end else begin
                            valid_out_reg    <= 1'b1;
                            res_out_reg      <= bus.in_res;
                            mux_out_reg      <= bus.in_mux;
                            memtoreg_out_reg <= bus.in_memtoreg;
                            regwrite_out_reg <= bus.in_regwrite & ~misal;
                            misalign_out_reg <= misal;
                            rdata_sel_reg    <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        valid_out_reg    <= 1'b1;
                        res_out_reg      <= res_reg;
                        mux_out_reg      <= mux_reg;
                        memtoreg_out_reg <= memtoreg_reg;
                        regwrite_out_reg <= regwrite_reg;
                        rdata_sel_reg    <= ~store_reg;
                        state_reg        <= IDLE;
                    end
                end
            endcase
        end
    end

    // Single-port RAM; a reset during BUSY returns the FSM to IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (done) begin
            if (store_reg) begin
                ram[idx] <= dat2_reg;
            end else begin
                ram_q <= ram[idx];
            end
        end
    end

    assign bus.ou_valid    = valid_out_reg;
    assign bus.ou_rdata    = rdata_sel_reg ? ram_q : 32'd0;
    assign bus.ou_res      = res_out_reg;
    assign bus.ou_mux      = mux_out_reg;
    assign bus.ou_memtoreg = memtoreg_out_reg;
    assign bus.ou_regwrite = regwrite_out_reg;
    assign bus.ou_misalign = misalign_out_reg;

`ifdef MEM_ERRCNT_EN
    logic [15:0] errcnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errcnt_reg <= 16'd0;
        end else if ((state_reg == IDLE) && bus.in_valid && misal && (errcnt_reg != 16'hFFFF)) begin
            errcnt_reg <= errcnt_reg + 16'd1;
        end
    end

    assign bus.ou_errcnt = errcnt_reg;
`endif

endmodule
